// File: rtl/fp_round_pack.sv
// Round-half-up and pack stage: {S,E,F} plus round bit in, 8-bit float out.
// Two-entry valid/ready pipeline with a sticky saturation counter.
module fp_round_pack #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [2:0]       in_exp,
   input  logic [3:0]       in_sig,
   input  logic             in_fifth,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_fp,
   output logic             out_sat,
   output logic [CNT_W-1:0] sat_count
);

   logic             s1_valid_q, s1_valid_d;
   logic             s1_sign_q, s1_sign_d;
   logic [2:0]       s1_exp_q, s1_exp_d;
   logic [4:0]       s1_sum_q, s1_sum_d;
   logic             s2_valid_q, s2_valid_d;
   logic [7:0]       s2_fp_q, s2_fp_d;
   logic             s2_sat_q, s2_sat_d;
   logic [CNT_W-1:0] sat_count_q, sat_count_d;

   logic             s2_en;
   logic             out_fire;
   logic [7:0]       rnd_fp;
   logic             rnd_sat;

   // A carry out of the significand renormalizes into the exponent,
   // unless the exponent is already at its maximum.
   always_comb begin
      rnd_sat = 1'b0;
      rnd_fp  = {s1_sign_q, s1_exp_q, s1_sum_q[3:0]};
      if (s1_sum_q[4]) begin
         if (s1_exp_q == 3'd7) begin
            rnd_sat = 1'b1;
            rnd_fp  = {s1_sign_q, 7'h7F};
         end else begin
            rnd_fp = {s1_sign_q, s1_exp_q + 3'd1, 4'b1000};
         end
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_exp_d    = s1_exp_q;
      s1_sum_d    = s1_sum_q;
      s2_valid_d  = s2_valid_q;
      s2_fp_d     = s2_fp_q;
      s2_sat_d    = s2_sat_q;
      sat_count_d = sat_count_q;

      s2_en    = !s2_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_en;
      out_fire = s2_valid_q && out_ready;

      if (s2_en) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_fp_d  = rnd_fp;
            s2_sat_d = rnd_sat;
         end
      end

      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_sign_d = in_sign;
            s1_exp_d  = in_exp;
            s1_sum_d  = {1'b0, in_sig} + {4'b0000, in_fifth};
         end
      end

      if (out_fire && s2_sat_q && (sat_count_q != {CNT_W{1'b1}}))
         sat_count_d = sat_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= 3'd0;
         s1_sum_q    <= 5'd0;
         s2_valid_q  <= 1'b0;
         s2_fp_q     <= 8'h00;
         s2_sat_q    <= 1'b0;
         sat_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_sum_q    <= s1_sum_d;
         s2_valid_q  <= s2_valid_d;
         s2_fp_q     <= s2_fp_d;
         s2_sat_q    <= s2_sat_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_fp    = s2_fp_q;
   assign out_sat   = s2_sat_q;
   assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboard bench for fp_round_pack: directed vectors with hand-computed
// packed results, checked in order by an independent output monitor.
module tb_fp_round_pack;

   typedef struct {
      logic [7:0] fp;
      logic       sat;
      int         cyc;
      bit         chk;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       in_sign = 1'b0;
   logic [2:0] in_exp = 3'd0;
   logic [3:0] in_sig = 4'd0;
   logic       in_fifth = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_fp;
   logic       out_sat;
   logic [7:0] sat_count;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   lat_en = 1'b0;
   bit   rnd_en = 1'b0;
   logic [7:0] cur_fp;
   logic       cur_sat;
   exp_t q[$];

   fp_round_pack #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp),
      .in_sig(in_sig), .in_fifth(in_fifth),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_fp(out_fp), .out_sat(out_sat),
      .sat_count(sat_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: pop/compare on output transfer, push on input transfer.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               check("out_fp", int'(out_fp), int'(e.fp));
               check("out_sat", int'(out_sat), int'(e.sat));
               if (e.chk) check("latency", cyc, e.cyc);
            end
         end
         if (in_valid && in_ready) begin
            e.fp  = cur_fp;
            e.sat = cur_sat;
            e.cyc = cyc + 2;
            e.chk = lat_en;
            q.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic set_in(input logic s, input logic [2:0] e,
                         input logic [3:0] f, input logic r,
                         input logic [7:0] xfp, input logic xsat);
      in_sign  = s;
      in_exp   = e;
      in_sig   = f;
      in_fifth = r;
      cur_fp   = xfp;
      cur_sat  = xsat;
      in_valid = 1'b1;
   endtask

   task automatic send(input logic s, input logic [2:0] e,
                       input logic [3:0] f, input logic r,
                       input logic [7:0] xfp, input logic xsat);
      bit acc;
      int g;
      set_in(s, e, f, r, xfp, xsat);
      acc = 1'b0;
      g = 0;
      while (!acc && g < 200) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         g++;
      end
      if (!acc) check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      int g;
      in_valid = 1'b0;
      rnd_en = 1'b0;
      out_ready = 1'b1;
      g = 0;
      while ((q.size() != 0 || out_valid) && g < 50) begin
         tick();
         g++;
      end
      if (g >= 50) check("drain_timeout", 0, 1);
   endtask

   initial begin
      logic [7:0] held;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_fp", int'(out_fp), 'h00);
      check("rst_out_sat", int'(out_sat), 0);
      check("rst_sat_count", int'(sat_count), 0);
      tick();

      // Basic rounding, carry, and saturation
      lat_en = 1'b1;
      send(0, 3'd3, 4'b1010, 1, 8'h3B, 0);
      send(0, 3'd3, 4'b1111, 1, 8'h48, 0);
      send(0, 3'd3, 4'b1111, 0, 8'h3F, 0);
      send(1, 3'd7, 4'b1111, 1, 8'hFF, 1);
      send(1, 3'd7, 4'b1111, 0, 8'hFF, 0);
      drain();
      lat_en = 1'b0;
      @(negedge clk);
      check("sat_count_1", int'(sat_count), 1);
      tick();

      // Streaming from an empty pipe: outputs at input+2, no gaps
      lat_en = 1'b1;
      send(0, 3'd0, 4'b0000, 1, 8'h01, 0);
      send(0, 3'd1, 4'b0111, 1, 8'h18, 0);
      send(1, 3'd2, 4'b0011, 0, 8'hA3, 0);
      send(1, 3'd6, 4'b1111, 1, 8'hF8, 0);
      drain();
      lat_en = 1'b0;
      tick();

      // Backpressure: two buffered, third waits
      out_ready = 1'b0;
      send(0, 3'd1, 4'b0000, 0, 8'h10, 0);
      send(0, 3'd2, 4'b0001, 0, 8'h21, 0);
      set_in(0, 3'd3, 4'b0010, 0, 8'h32, 0);
      @(negedge clk);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_head", int'(out_fp), 'h10);
      held = out_fp;
      tick();
      tick();
      @(negedge clk);
      check("bp_stable", int'(out_fp), int'(held));
      check("bp_still_full", int'(in_ready), 0);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_release", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_second", int'(out_fp), 'h21);
      drain();
      tick();

      // Random out_ready toggling
      rnd_en = 1'b1;
      send(0, 3'd5, 4'b0101, 0, 8'h55, 0);
      send(0, 3'd5, 4'b0101, 1, 8'h56, 0);
      send(1, 3'd0, 4'b1111, 1, 8'h98, 0);
      send(0, 3'd7, 4'b1110, 1, 8'h7F, 0);
      send(0, 3'd7, 4'b1111, 1, 8'h7F, 1);
      send(1, 3'd4, 4'b1001, 1, 8'hCA, 0);
      send(0, 3'd2, 4'b1111, 0, 8'h2F, 0);
      send(1, 3'd1, 4'b0000, 0, 8'h90, 0);
      send(1, 3'd7, 4'b1111, 1, 8'hFF, 1);
      drain();
      @(negedge clk);
      check("sat_count_3", int'(sat_count), 3);
      tick();

      // Reset with two items in flight
      out_ready = 1'b0;
      send(0, 3'd1, 4'b0000, 0, 8'h10, 0);
      send(0, 3'd2, 4'b0001, 0, 8'h21, 0);
      rst = 1'b1;
      set_in(1, 3'd7, 4'b1111, 1, 8'hFF, 1);
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("rr_out_valid", int'(out_valid), 0);
      check("rr_out_fp", int'(out_fp), 'h00);
      check("rr_sat_count", int'(sat_count), 0);
      check("rr_in_ready", int'(in_ready), 1);
      tick();
      @(negedge clk);
      check("rr_no_capture", int'(out_valid), 0);
      tick();

      // Counter sticks at all-ones
      for (int i = 0; i < 256; i++)
         send(1'(i), 3'd7, 4'b1111, 1, {1'(i), 7'h7F}, 1);
      drain();
      @(negedge clk);
      check("sat_count_255", int'(sat_count), 255);
      tick();
      send(0, 3'd7, 4'b1111, 1, 8'h7F, 1);
      drain();
      @(negedge clk);
      check("sat_count_hold", int'(sat_count), 255);
      check("queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
